// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atm_pkg
// Description : Shared types and constants for the ATM keypad front end and
//               the Atm controller: scanner state encoding, column reset
//               pattern, menu key codes, and small keypad helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package atm_pkg;

   // Scanner state encoding, explicit 3-bit width
   typedef enum logic [2:0] {
      SCAN         = 3'd0,
      DEBOUNCE     = 3'd1,
      LOAD         = 3'd2,
      STROBE       = 3'd3,
      WAIT_RELEASE = 3'd4
   } scan_state_t;

   // Column 0 driven low, the others released
   localparam logic [3:0] COL_RESET = 4'b1110;

   // Menu key codes interpreted by the Atm controller
   localparam logic [3:0] KEY_BALANCE  = 4'h1;
   localparam logic [3:0] KEY_WITHDRAW = 4'h2;
   localparam logic [3:0] KEY_DEPOSIT  = 4'h3;
   localparam logic [3:0] KEY_TRANSFER = 4'h4;
   localparam logic [3:0] KEY_CHPASS   = 4'h5;
   localparam logic [3:0] KEY_EXIT     = 4'h6;

   // Index of the lowest-numbered active-low row; only meaningful when at
   // least one row is low.
   function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
      if (!rows[0])
         return 2'd0;
      else if (!rows[1])
         return 2'd1;
      else if (!rows[2])
         return 2'd2;
      else
         return 2'd3;
   endfunction

   // Move the single low bit to the next column, 3 wrapping back to 0
   function automatic logic [3:0] rotate_col(input logic [3:0] col);
      return {col[2:0], col[3]};
   endfunction

endpackage : atm_pkg
`default_nettype wire

// File: rtl/atm_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : atm_sync_2ff
// Description : Two-flop synchroniser for asynchronous active-low inputs.
//               Reset forces both stages to all-ones (the idle level).
// Ports       : clk  in  1      system clock
//               rst  in  1      asynchronous active-high reset
//               d    in  WIDTH  asynchronous input
//               q    out WIDTH  synchronised output
// Revision    : 1.0 - initial release
// ============================================================================
module atm_sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_stage1;
   logic [WIDTH-1:0] r_stage2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stage1 <= '1;
         r_stage2 <= '1;
      end else begin
         r_stage1 <= d;
         r_stage2 <= r_stage1;
      end
   end

   assign q = r_stage2;

endmodule : atm_sync_2ff
`default_nettype wire

// File: rtl/atm_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : atm_keypad_scanner
// Description : Scans a 4x4 active-low matrix keypad, debounces press and
//               release, and emits one key code per press on userInput with
//               a fixed-width NewInput strobe for the Atm controller.
// Ports       : clk        in  1  system clock
//               rst        in  1  asynchronous active-high reset
//               row_sense  in  4  keypad rows, active-low, asynchronous
//               col_drive  out 4  keypad columns, active-low one-hot
//               userInput  out 4  {row_idx, col_idx} of last accepted key
//               NewInput   out 1  key strobe, STROBE_CYCLES wide
//               key_busy   out 1  press detected and not yet released
// Revision    : 1.0 - initial release
// ============================================================================
module atm_keypad_scanner
   import atm_pkg::*;
#(
   parameter int SCAN_DIV        = 16,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int STROBE_CYCLES   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_sense,
   output logic [3:0] col_drive,
   output logic [3:0] userInput,
   output logic       NewInput,
   output logic       key_busy
);

   localparam int C_MAX_AB = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int C_CNT_MAX = (C_MAX_AB > STROBE_CYCLES) ? C_MAX_AB : STROBE_CYCLES;
   localparam int CNT_W = $clog2(C_CNT_MAX + 1);

   localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_STB_END  = CNT_W'(STROBE_CYCLES);

   // Cycles to ignore rows after a column change: the two synchroniser
   // stages still hold samples taken under the previous column.
   localparam logic [1:0] C_SETTLE = 2'd2;

   scan_state_t      r_state;
   logic [3:0]       r_col_drive;
   logic [1:0]       r_col_idx;
   logic [1:0]       r_row_idx;
   logic [CNT_W-1:0] r_div;
   logic [CNT_W-1:0] r_deb;
   logic [CNT_W-1:0] r_strobe;
   logic [1:0]       r_settle;
   logic [3:0]       r_user_input;
   logic             r_new_input;
   logic             r_key_busy;

   logic [3:0]       w_rows;

   atm_sync_2ff #(
      .WIDTH (4)
   ) u_row_sync (
      .clk (clk),
      .rst (rst),
      .d   (row_sense),
      .q   (w_rows)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= SCAN;
         r_col_drive  <= COL_RESET;
         r_col_idx    <= 2'd0;
         r_row_idx    <= 2'd0;
         r_div        <= '0;
         r_deb        <= '0;
         r_strobe     <= '0;
         r_settle     <= 2'd0;
         r_user_input <= 4'h0;
         r_new_input  <= 1'b0;
         r_key_busy   <= 1'b0;
      end else begin
         case (r_state)
            SCAN: begin
               if ((r_settle == 2'd0) && (w_rows != 4'hF)) begin
                  // Press seen: freeze the column and start debouncing
                  r_row_idx  <= low_row_idx(w_rows);
                  r_key_busy <= 1'b1;
                  r_deb      <= '0;
                  r_state    <= DEBOUNCE;
               end else begin
                  if (r_settle != 2'd0)
                     r_settle <= r_settle - 2'd1;
                  if (r_div == C_DIV_LAST) begin
                     r_div       <= '0;
                     r_col_drive <= rotate_col(r_col_drive);
                     r_col_idx   <= r_col_idx + 2'd1;
                     r_settle    <= C_SETTLE;
                  end else begin
                     r_div <= r_div + C_ONE;
                  end
               end
            end

            DEBOUNCE: begin
               if (!w_rows[r_row_idx]) begin
                  if (r_deb == C_DEB_LAST) begin
                     r_deb   <= '0;
                     r_state <= LOAD;
                  end else begin
                     r_deb <= r_deb + C_ONE;
                  end
               end else begin
                  // Bounce: drop the candidate and resume at the next column
                  r_deb       <= '0;
                  r_key_busy  <= 1'b0;
                  r_div       <= '0;
                  r_col_drive <= rotate_col(r_col_drive);
                  r_col_idx   <= r_col_idx + 2'd1;
                  r_settle    <= C_SETTLE;
                  r_state     <= SCAN;
               end
            end

            LOAD: begin
               // Code goes out one cycle ahead of the strobe rising edge
               r_user_input <= {r_row_idx, r_col_idx};
               r_strobe     <= '0;
               r_state      <= STROBE;
            end

            STROBE: begin
               // Row activity is ignored here so the pulse width is fixed
               if (r_strobe == C_STB_END) begin
                  r_new_input <= 1'b0;
                  r_strobe    <= '0;
                  r_deb       <= '0;
                  r_state     <= WAIT_RELEASE;
               end else begin
                  r_new_input <= 1'b1;
                  r_strobe    <= r_strobe + C_ONE;
               end
            end

            WAIT_RELEASE: begin
               // Any low row (held or second key) restarts the release count
               if (w_rows == 4'hF) begin
                  if (r_deb == C_DEB_LAST) begin
                     r_deb       <= '0;
                     r_key_busy  <= 1'b0;
                     r_div       <= '0;
                     r_col_drive <= rotate_col(r_col_drive);
                     r_col_idx   <= r_col_idx + 2'd1;
                     r_settle    <= C_SETTLE;
                     r_state     <= SCAN;
                  end else begin
                     r_deb <= r_deb + C_ONE;
                  end
               end else begin
                  r_deb <= '0;
               end
            end

            default: begin
               r_state <= SCAN;
            end
         endcase
      end
   end

   assign col_drive = r_col_drive;
   assign userInput = r_user_input;
   assign NewInput  = r_new_input;
   assign key_busy  = r_key_busy;

endmodule : atm_keypad_scanner
`default_nettype wire

// File: tb/tb_atm_keypad_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_atm_keypad_scanner
// Description : Directed bench for atm_keypad_scanner. A keypad model pulls a
//               row low only while its column is driven; expected key codes
//               are queued at stimulus time and compared on each NewInput
//               rising edge together with setup and pulse-width checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atm_keypad_scanner;
   import atm_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row_sense;
   logic [3:0] col_drive;
   logic [3:0] userInput;
   logic       NewInput;
   logic       key_busy;

   logic [15:0] key_down;          // bit r*4+c = key at row r, column c held

   int          errors = 0;
   int          checks = 0;
   logic [3:0]  exp_q[$];
   int          pulse_count = 0;
   int          width = 0;
   logic        prev_ni = 1'b0;
   logic [3:0]  prev_ui = 4'h0;
   bit          busy_seen = 1'b0;

   atm_keypad_scanner #(
      .SCAN_DIV        (16),
      .DEBOUNCE_CYCLES (4),
      .STROBE_CYCLES   (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_sense (row_sense),
      .col_drive (col_drive),
      .userInput (userInput),
      .NewInput  (NewInput),
      .key_busy  (key_busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      row_sense = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (key_down[r*4+c] && !col_drive[c])
               row_sense[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: runs on the falling edge, away from the DUT's edge
   always @(negedge clk) begin
      if (rst) begin
         prev_ni = 1'b0;
         prev_ui = userInput;
         width   = 0;
      end else begin
         if (key_busy)
            busy_seen = 1'b1;
         if (NewInput && !prev_ni) begin
            pulse_count++;
            if (exp_q.size() == 0) begin
               check("pulse_was_expected", exp_q.size(), 1);
            end else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               check("user_input", userInput, e);
               check("user_input_setup", prev_ui, userInput);
            end
         end
         if (NewInput)
            width++;
         if (!NewInput && prev_ni) begin
            check("strobe_width", width, 8);
            width = 0;
         end
         prev_ni = NewInput;
         prev_ui = userInput;
      end
   end

   // One stimulus step: 2 ns after the rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_pulses(input int n, input int budget, input string tag);
      int k = 0;
      while (pulse_count < n && k < budget) begin
         tick(1);
         k++;
      end
      check(tag, pulse_count, n);
   endtask

   task automatic wait_col(input logic [3:0] target, input int budget, input string tag);
      int k = 0;
      while (col_drive !== target && k < budget) begin
         tick(1);
         k++;
      end
      check(tag, col_drive, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_cols [5];
      exp_cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

      rst      = 1'b1;
      key_down = 16'h0;
      tick(3);
      check("reset_col_drive", col_drive, 4'b1110);
      check("reset_user_input", userInput, 4'h0);
      check("reset_new_input", NewInput, 1'b0);
      check("reset_key_busy", key_busy, 1'b0);
      rst = 1'b0;

      // Idle column rotation, sampled mid-window
      tick(8);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("idle_col_%0d", i), col_drive, exp_cols[i]);
         tick(16);
      end

      // Clean press row0/col1, held 200 cycles
      key_down[0*4+1] = 1'b1;
      exp_q.push_back(KEY_BALANCE);
      tick(200);
      check("t1_single_pulse", pulse_count, 1);
      check("t1_busy_held", key_busy, 1'b1);
      key_down = 16'h0;
      tick(30);
      check("t1_busy_released", key_busy, 1'b0);

      // Bouncing press row2/col3
      wait_col(4'b0111, 80, "t2_reach_col3");
      tick(4);
      busy_seen = 1'b0;
      key_down[2*4+3] = 1'b1;
      tick(3);
      key_down[2*4+3] = 1'b0;
      tick(2);
      key_down[2*4+3] = 1'b1;
      exp_q.push_back(4'hB);
      wait_pulses(2, 150, "t2_bounce_pulse");
      tick(20);
      check("t2_bounce_single_event", pulse_count, 2);
      check("t2_bounce_busy_seen", busy_seen, 1'b1);
      key_down = 16'h0;
      tick(30);

      // Glitch alone: busy rises then falls, no event
      wait_col(4'b0111, 80, "t2_reach_col3_glitch");
      tick(4);
      busy_seen = 1'b0;
      key_down[2*4+3] = 1'b1;
      tick(3);
      key_down[2*4+3] = 1'b0;
      tick(100);
      check("t2_glitch_no_event", pulse_count, 2);
      check("t2_glitch_busy_seen", busy_seen, 1'b1);
      check("t2_glitch_busy_clear", key_busy, 1'b0);

      // Two rows in column 2: lowest row wins
      key_down[1*4+2] = 1'b1;
      key_down[3*4+2] = 1'b1;
      exp_q.push_back(4'h6);
      wait_pulses(3, 150, "t3_pulse");
      tick(20);
      check("t3_single_event", pulse_count, 3);
      key_down = 16'h0;
      tick(30);
      check("t3_busy_released", key_busy, 1'b0);

      // Reset in the middle of a strobe, key held throughout
      key_down[3*4+1] = 1'b1;
      exp_q.push_back(4'hD);
      wait_pulses(4, 150, "t5_first_pulse");
      tick(1);
      check("t5_strobe_active", NewInput, 1'b1);
      check("t5_col_frozen", col_drive, 4'b1101);
      rst = 1'b1;
      #1;
      check("t5_rst_new_input", NewInput, 1'b0);
      check("t5_rst_col_drive", col_drive, 4'b1110);
      check("t5_rst_user_input", userInput, 4'h0);
      check("t5_rst_key_busy", key_busy, 1'b0);
      exp_q.push_back(4'hD);
      tick(2);
      rst = 1'b0;
      wait_pulses(5, 150, "t5_redetect_pulse");
      tick(20);
      key_down = 16'h0;
      tick(30);

      // Card, password, balance selection: three presses of key 1
      for (int i = 0; i < 3; i++) begin
         key_down[0*4+1] = 1'b1;
         exp_q.push_back(KEY_BALANCE);
         wait_pulses(6 + i, 150, $sformatf("t6_press_%0d", i));
         tick(12);
         key_down = 16'h0;
         tick(30);
      end
      check("t6_three_edges", pulse_count - 5, 3);
      check("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_atm_keypad_scanner
`default_nettype wire
